// File: rtl/tdc_mlt_sched_if.sv
// tdc_mlt_sched_if
// Bundles the scheduler's channel capture inputs, the shared mlt datapath
// handshake and the tagged result stream.
//   slave  : seen by the scheduler (captures/datapath return in, grants/results out)
//   master : seen by the environment (TDC capture logic, datapath, event packer)
// Signals:
//   ch_valid/ch_int/ch_frac   per-channel capture strobe and coarse/fine pair
//   ch_pend/ch_ovf            holding register occupied / sticky capture loss
//   mlt_start/mlt_int/mlt_frac  request to the combining datapath
//   mlt_dval/mlt_result       datapath return
//   res_valid/res_ch/res_data tagged result strobe
//   seq_err/clr_err           sticky tag-pipeline disagreement / clear of sticky flags
interface tdc_mlt_sched_if #(
    parameter int NCH    = 8,
    parameter int INT_W  = 11,
    parameter int FRAC_W = 11,
    parameter int OUT_W  = 37
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]             ch_valid;
    logic [NCH-1:0][INT_W-1:0]  ch_int;
    logic [NCH-1:0][FRAC_W-1:0] ch_frac;
    logic [NCH-1:0]             ch_pend;
    logic [NCH-1:0]             ch_ovf;
    logic                       mlt_start;
    logic [INT_W-1:0]           mlt_int;
    logic [FRAC_W-1:0]          mlt_frac;
    logic                       mlt_dval;
    logic [OUT_W-1:0]           mlt_result;
    logic                       res_valid;
    logic [CW-1:0]              res_ch;
    logic [OUT_W-1:0]           res_data;
    logic                       seq_err;
    logic                       clr_err;

    modport slave (
        input  ch_valid, ch_int, ch_frac, mlt_dval, mlt_result, clr_err,
        output ch_pend, ch_ovf, mlt_start, mlt_int, mlt_frac,
               res_valid, res_ch, res_data, seq_err
    );

    modport master (
        output ch_valid, ch_int, ch_frac, mlt_dval, mlt_result, clr_err,
        input  ch_pend, ch_ovf, mlt_start, mlt_int, mlt_frac,
               res_valid, res_ch, res_data, seq_err
    );
endinterface

// File: rtl/tdc_mlt_sched.sv
// tdc_mlt_sched
// Round-robin scheduler sharing one mlt coarse/fine combining datapath
// (LAT-cycle latency) between NCH TDC channels. Each channel owns a one-deep
// holding register; at most one request is issued per clock, its channel tag
// travels alongside the datapath and the returning result is tagged with it.
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   sched_if  tdc_mlt_sched_if.slave (capture, datapath and result signals)
module tdc_mlt_sched #(
    parameter int NCH    = 8,
    parameter int INT_W  = 11,
    parameter int FRAC_W = 11,
    parameter int OUT_W  = 37,
    parameter int LAT    = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    tdc_mlt_sched_if.slave    sched_if
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]             r_pend;
    logic [NCH-1:0]             r_ovf;
    logic [NCH-1:0][INT_W-1:0]  r_hold_int;
    logic [NCH-1:0][FRAC_W-1:0] r_hold_frac;
    logic [CW-1:0]              r_rr_ptr;

    logic                       r_start;
    logic [INT_W-1:0]           r_mlt_int;
    logic [FRAC_W-1:0]          r_mlt_frac;

    // Tag pipeline: index 0 is loaded together with mlt_start, index LAT
    // lines up with the cycle the datapath raises mlt_dval.
    logic [LAT:0]               r_tag_v;
    logic [LAT:0][CW-1:0]       r_tag_ch;

    logic                       r_res_valid;
    logic [CW-1:0]              r_res_ch;
    logic [OUT_W-1:0]           r_res_data;
    logic                       r_seq_err;

    logic                       w_gnt_any;
    logic [CW-1:0]              w_gnt_idx;
    logic [NCH-1:0]             w_gnt;
    logic [CW-1:0]              w_rr_next;
    logic                       w_tail_v;

    // Search pending channels starting at r_rr_ptr, wrapping at NCH-1.
    always_comb begin
        logic [CW:0] idx;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt     = '0;
        idx       = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = {1'b0, r_rr_ptr} + (CW+1)'(i);
            if (idx >= (CW+1)'(NCH)) begin
                idx = idx - (CW+1)'(NCH);
            end
            if (!w_gnt_any && r_pend[idx[CW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = idx[CW-1:0];
            end
        end
        if (w_gnt_any) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign w_rr_next = (w_gnt_idx == CW'(NCH-1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_tail_v  = r_tag_v[LAT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend      <= '0;
            r_ovf       <= '0;
            r_hold_int  <= '0;
            r_hold_frac <= '0;
            r_rr_ptr    <= '0;
            r_start     <= 1'b0;
            r_mlt_int   <= '0;
            r_mlt_frac  <= '0;
            r_tag_v     <= '0;
            r_tag_ch    <= '0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_data  <= '0;
            r_seq_err   <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                // A capture landing on the grant cycle refills the slot that
                // is being emptied, so it is accepted rather than lost.
                if (sched_if.ch_valid[c] && (!r_pend[c] || w_gnt[c])) begin
                    r_hold_int[c]  <= sched_if.ch_int[c];
                    r_hold_frac[c] <= sched_if.ch_frac[c];
                end
                r_pend[c] <= sched_if.ch_valid[c] | (r_pend[c] & ~w_gnt[c]);
                if (sched_if.ch_valid[c] && r_pend[c] && !w_gnt[c]) begin
                    r_ovf[c] <= 1'b1;
                end else if (sched_if.clr_err) begin
                    r_ovf[c] <= 1'b0;
                end
            end

            if (w_gnt_any) begin
                r_start    <= 1'b1;
                r_mlt_int  <= r_hold_int[w_gnt_idx];
                r_mlt_frac <= r_hold_frac[w_gnt_idx];
                r_rr_ptr   <= w_rr_next;
            end else begin
                r_start    <= 1'b0;
                r_mlt_int  <= '0;
                r_mlt_frac <= '0;
            end

            r_tag_v  <= {r_tag_v[LAT-1:0], w_gnt_any};
            r_tag_ch <= {r_tag_ch[LAT-1:0], w_gnt_idx};

            r_res_valid <= w_tail_v & sched_if.mlt_dval;
            if (w_tail_v && sched_if.mlt_dval) begin
                r_res_ch   <= r_tag_ch[LAT];
                r_res_data <= sched_if.mlt_result;
            end

            if (w_tail_v ^ sched_if.mlt_dval) begin
                r_seq_err <= 1'b1;
            end else if (sched_if.clr_err) begin
                r_seq_err <= 1'b0;
            end
        end
    end

    assign sched_if.ch_pend   = r_pend;
    assign sched_if.ch_ovf    = r_ovf;
    assign sched_if.mlt_start = r_start;
    assign sched_if.mlt_int   = r_mlt_int;
    assign sched_if.mlt_frac  = r_mlt_frac;
    assign sched_if.res_valid = r_res_valid;
    assign sched_if.res_ch    = r_res_ch;
    assign sched_if.res_data  = r_res_data;
    assign sched_if.seq_err   = r_seq_err;
endmodule

// File: tb/tb_tdc_mlt_sched.sv
module tb_tdc_mlt_sched;
    localparam int NCH    = 8;
    localparam int INT_W  = 11;
    localparam int FRAC_W = 11;
    localparam int OUT_W  = 37;
    localparam int LAT    = 3;

    logic clk;
    logic rst_n;
    logic inj_dval;
    int   cyc;
    int   n_chk;
    int   n_err;
    int   c0;
    int   exp_g [8];

    typedef struct {
        int          ch;
        logic [63:0] data;
        int          cyc;
    } res_t;

    res_t res_q[$];
    int   g_q[$];

    tdc_mlt_sched_if #(.NCH(NCH), .INT_W(INT_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) bus ();

    tdc_mlt_sched #(
        .NCH(NCH), .INT_W(INT_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .LAT(LAT)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sched_if(bus.slave)
    );

    // Behavioural datapath: result = int*50 + frac, out_dval 3 cycles after start.
    logic [2:0]            dp_v;
    logic [2:0][OUT_W-1:0] dp_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_v <= '0;
            dp_r <= '0;
        end else begin
            dp_v <= {dp_v[1:0], bus.mlt_start};
            dp_r <= {dp_r[1:0], OUT_W'(bus.mlt_int) * OUT_W'(50) + OUT_W'(bus.mlt_frac)};
        end
    end

    assign bus.mlt_dval   = dp_v[2] | inj_dval;
    assign bus.mlt_result = dp_r[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.res_valid === 1'b1) begin
            res_q.push_back('{int'(bus.res_ch), 64'(bus.res_data), cyc});
        end
        if (bus.mlt_start === 1'b1) begin
            g_q.push_back(int'(bus.mlt_int));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int q_gnt(input int i);
        return (i < g_q.size()) ? g_q[i] : -1;
    endfunction

    function automatic int q_ch(input int i);
        return (i < res_q.size()) ? res_q[i].ch : -1;
    endfunction

    function automatic logic [63:0] q_data(input int i);
        return (i < res_q.size()) ? res_q[i].data : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic int q_cyc(input int i);
        return (i < res_q.size()) ? res_q[i].cyc : -1;
    endfunction

    initial begin
        cyc          = 0;
        n_chk        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        inj_dval     = 1'b0;
        bus.ch_valid = '0;
        bus.ch_int   = '0;
        bus.ch_frac  = '0;
        bus.clr_err  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pend",   64'(bus.ch_pend), 64'd0);
        chk("rst_ovf",    64'(bus.ch_ovf), 64'd0);
        chk("rst_start",  64'(bus.mlt_start), 64'd0);
        chk("rst_int",    64'(bus.mlt_int), 64'd0);
        chk("rst_frac",   64'(bus.mlt_frac), 64'd0);
        chk("rst_rvalid", 64'(bus.res_valid), 64'd0);
        chk("rst_rdata",  64'(bus.res_data), 64'd0);
        chk("rst_seqerr", 64'(bus.seq_err), 64'd0);
        rst_n = 1'b1;
        step();

        // All 8 channels strobe together, rr_ptr at 0
        res_q.delete();
        g_q.delete();
        c0 = cyc;
        bus.ch_valid = 8'hFF;
        for (int c = 0; c < NCH; c++) begin
            bus.ch_int[c]  = INT_W'(c);
            bus.ch_frac[c] = FRAC_W'(1);
        end
        step();
        bus.ch_valid = '0;
        chk("all_pend", 64'(bus.ch_pend), 64'hFF);
        step(13);
        chk("all_ngnt", 64'(g_q.size()), 64'd8);
        chk("all_nres", 64'(res_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("all_gnt%0d", i),  64'(q_gnt(i)), 64'(i));
            chk($sformatf("all_ch%0d", i),   64'(q_ch(i)), 64'(i));
            chk($sformatf("all_data%0d", i), q_data(i), 64'(50 * i + 1));
            chk($sformatf("all_cyc%0d", i),  64'(q_cyc(i) - c0), 64'(6 + i));
        end
        chk("all_ovf", 64'(bus.ch_ovf), 64'd0);

        // Fairness: ch1/ch5 re-captured on their own grant cycles
        res_q.delete();
        g_q.delete();
        exp_g = '{100, 200, 101, 202, 103, 204, 105, 206};
        bus.ch_valid   = 8'h22;
        bus.ch_int[1]  = INT_W'(100);
        bus.ch_int[5]  = INT_W'(200);
        bus.ch_frac    = '0;
        step();
        for (int k = 1; k <= 6; k++) begin
            if (k % 2 == 1) begin
                bus.ch_valid  = 8'h02;
                bus.ch_int[1] = INT_W'(100 + k);
            end else begin
                bus.ch_valid  = 8'h20;
                bus.ch_int[5] = INT_W'(200 + k);
            end
            step();
        end
        bus.ch_valid = '0;
        step(8);
        chk("fair_ngnt", 64'(g_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fair_gnt%0d", i),  64'(q_gnt(i)), 64'(exp_g[i]));
            chk($sformatf("fair_ch%0d", i),   64'(q_ch(i)), (i % 2 == 0) ? 64'd1 : 64'd5);
            chk($sformatf("fair_data%0d", i), q_data(i), 64'(50 * exp_g[i]));
        end
        chk("fair_ovf",  64'(bus.ch_ovf), 64'd0);
        chk("fair_pend", 64'(bus.ch_pend), 64'd0);

        // Overflow: ch3 strobed twice while ch0..2 pending (rr_ptr now 6)
        res_q.delete();
        g_q.delete();
        bus.ch_valid = 8'h0F;
        for (int c = 0; c < 4; c++) begin
            bus.ch_int[c]  = INT_W'(10 + c);
            bus.ch_frac[c] = FRAC_W'(c);
        end
        step();
        bus.ch_valid   = 8'h08;
        bus.ch_int[3]  = INT_W'(99);
        bus.ch_frac[3] = FRAC_W'(9);
        step();
        bus.ch_valid = '0;
        chk("ovf_flag", 64'(bus.ch_ovf), 64'h08);
        chk("ovf_pend", 64'(bus.ch_pend), 64'h0E);
        step(10);
        chk("ovf_sticky", 64'(bus.ch_ovf), 64'h08);
        chk("ovf_ngnt", 64'(g_q.size()), 64'd4);
        chk("ovf_gnt3", 64'(q_gnt(3)), 64'd13);
        chk("ovf_ch3",  64'(q_ch(3)), 64'd3);
        chk("ovf_data3", q_data(3), 64'd653);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        chk("ovf_clr", 64'(bus.ch_ovf), 64'd0);

        // Spurious mlt_dval with empty tag pipeline
        res_q.delete();
        inj_dval = 1'b1;
        step();
        inj_dval = 1'b0;
        chk("spur_err",    64'(bus.seq_err), 64'd1);
        chk("spur_rvalid", 64'(bus.res_valid), 64'd0);
        step();
        chk("spur_sticky", 64'(bus.seq_err), 64'd1);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        chk("spur_clr",  64'(bus.seq_err), 64'd0);
        chk("spur_nres", 64'(res_q.size()), 64'd0);

        // Reset with 4 requests in flight
        bus.ch_valid = 8'h0F;
        for (int c = 0; c < 4; c++) begin
            bus.ch_int[c]  = INT_W'(20 + c);
            bus.ch_frac[c] = '0;
        end
        step();
        bus.ch_valid = '0;
        step(4);
        chk("mid_start_pre", 64'(bus.mlt_start), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_start",  64'(bus.mlt_start), 64'd0);
        chk("mid_int",    64'(bus.mlt_int), 64'd0);
        chk("mid_pend",   64'(bus.ch_pend), 64'd0);
        chk("mid_rvalid", 64'(bus.res_valid), 64'd0);
        step(2);
        rst_n = 1'b1;
        res_q.delete();
        step(10);
        chk("mid_nres", 64'(res_q.size()), 64'd0);

        // Single request after reset
        bus.ch_valid   = 8'h04;
        bus.ch_int[2]  = INT_W'(7);
        bus.ch_frac[2] = FRAC_W'(13);
        chk("one_pend0", 64'(bus.ch_pend), 64'd0);
        step();
        bus.ch_valid = '0;
        chk("one_pend1",  64'(bus.ch_pend), 64'h04);
        chk("one_start1", 64'(bus.mlt_start), 64'd0);
        step();
        chk("one_start2", 64'(bus.mlt_start), 64'd1);
        chk("one_int2",   64'(bus.mlt_int), 64'd7);
        chk("one_frac2",  64'(bus.mlt_frac), 64'd13);
        chk("one_pend2",  64'(bus.ch_pend), 64'd0);
        step();
        chk("one_start3", 64'(bus.mlt_start), 64'd0);
        chk("one_int3",   64'(bus.mlt_int), 64'd0);
        step(2);
        chk("one_rvalid5", 64'(bus.res_valid), 64'd0);
        step();
        chk("one_rvalid6", 64'(bus.res_valid), 64'd1);
        chk("one_rch6",    64'(bus.res_ch), 64'd2);
        chk("one_rdata6",  64'(bus.res_data), 64'd363);
        step();
        chk("one_rvalid7", 64'(bus.res_valid), 64'd0);
        chk("one_seqerr",  64'(bus.seq_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
